pipe_stage_hs: RTL

//  Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_perf_cnt.sv | 25 ++
 rtl/pipe_stage_hs.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake state encoding, per-boundary
// payload widths and the EX/MEM field layout used by the instantiating stages.
package pipe_pkg;

   // Occupancy of a handshake stage: nothing held, main register only, main + skid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Architectural field widths
   localparam int unsigned PC_W     = 32;
   localparam int unsigned RESULT_W = 32;
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned MSG_W    = 4;
   localparam int unsigned CTL_W    = 5;

   // Payload width per pipeline boundary
   localparam int unsigned IF_ID_PAYLOAD_W  = PC_W + INSTR_W;
   localparam int unsigned ID_EX_PAYLOAD_W  = PC_W + 2 * RESULT_W + 3 * REG_W + CTL_W;
   localparam int unsigned EX_MEM_PAYLOAD_W = PC_W + RESULT_W + 3 * REG_W + MSG_W + CTL_W;
   localparam int unsigned MEM_WB_PAYLOAD_W = RESULT_W + REG_W + CTL_W;

   // EX/MEM payload field offsets (LSB position), ctl in the low bits, pc on top
   localparam int unsigned EX_MEM_CTL_OFS    = 0;
   localparam int unsigned EX_MEM_MSG_OFS    = EX_MEM_CTL_OFS + CTL_W;
   localparam int unsigned EX_MEM_RD_OFS     = EX_MEM_MSG_OFS + MSG_W;
   localparam int unsigned EX_MEM_RS2_OFS    = EX_MEM_RD_OFS + REG_W;
   localparam int unsigned EX_MEM_RS1_OFS    = EX_MEM_RS2_OFS + REG_W;
   localparam int unsigned EX_MEM_RESULT_OFS = EX_MEM_RS1_OFS + REG_W;
   localparam int unsigned EX_MEM_PC_OFS     = EX_MEM_RESULT_OFS + RESULT_W;

endpackage : pipe_pkg

// File: rtl/pipe_perf_cnt.sv
// Free-running event counter: increments once per enabled cycle, wraps at 2^CNT_W,
// cleared only by the asynchronous active-low reset.
module pipe_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Count enabled cycles, natural wrap on overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule : pipe_perf_cnt

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
// Full throughput; up_ready comes straight from a flop so no combinational
// ready path crosses stages. dn_data is driven directly by the main register.
// Optional stall/bubble performance counters: define PIPE_STAGE_PERF_EN.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int unsigned          PAYLOAD_W = EX_MEM_PAYLOAD_W,
   parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int unsigned          CNT_W     = 32
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [PAYLOAD_W-1:0] up_data,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic [PAYLOAD_W-1:0] dn_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]     cnt_stall,
   output logic [CNT_W-1:0]     cnt_bubble
`endif
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [PAYLOAD_W-1:0]   r_main;
   logic [PAYLOAD_W-1:0]   r_skid;
   logic [PAYLOAD_W-1:0]   w_main_nxt;
   logic [PAYLOAD_W-1:0]   w_skid_nxt;
   logic                   r_dn_valid;
   logic                   r_up_ready;
   logic                   w_dn_valid_nxt;
   logic                   w_up_ready_nxt;
   logic                   w_accept;
   logic                   w_deliver;

   assign w_accept  = up_valid & r_up_ready;
   assign w_deliver = r_dn_valid & dn_ready;

   // State, payload and handshake registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_EMPTY;
         r_main     <= RST_VAL;
         r_skid     <= '0;
         r_dn_valid <= 1'b0;
         r_up_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_dn_valid <= w_dn_valid_nxt;
         r_up_ready <= w_up_ready_nxt;
      end
   end

   // Next-state logic; flush overrides every handshake event, M keeps its value
   always_comb begin
      w_state_nxt    = r_state;
      w_main_nxt     = r_main;
      w_skid_nxt     = r_skid;
      w_dn_valid_nxt = r_dn_valid;
      w_up_ready_nxt = r_up_ready;
      if (flush) begin
         w_state_nxt    = ST_EMPTY;
         w_dn_valid_nxt = 1'b0;
         w_up_ready_nxt = 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt    = ST_BUSY;
                  w_main_nxt     = up_data;
                  w_dn_valid_nxt = 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_accept && w_deliver) begin
                  w_main_nxt = up_data;
               end else if (w_accept) begin
                  w_state_nxt    = ST_FULL;
                  w_skid_nxt     = up_data;
                  w_up_ready_nxt = 1'b0;
               end else if (w_deliver) begin
                  w_state_nxt    = ST_EMPTY;
                  w_dn_valid_nxt = 1'b0;
               end
            end
            ST_FULL: begin
               if (w_deliver) begin
                  w_state_nxt    = ST_BUSY;
                  w_main_nxt     = r_skid;
                  w_up_ready_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt    = ST_EMPTY;
               w_dn_valid_nxt = 1'b0;
               w_up_ready_nxt = 1'b1;
            end
         endcase
      end
   end

   assign up_ready = r_up_ready;
   assign dn_valid = r_dn_valid;
   assign dn_data  = r_main;

`ifdef PIPE_STAGE_PERF_EN
   logic w_stall_en;
   logic w_bubble_en;

   assign w_stall_en  = r_dn_valid & ~dn_ready;
   assign w_bubble_en = ~r_dn_valid;

   // Cycles where downstream holds off a presented beat
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_stall_en),
      .o_cnt (cnt_stall)
   );

   // Cycles with nothing presented downstream
   pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_bubble (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_bubble_en),
      .o_cnt (cnt_bubble)
   );
`endif

endmodule : pipe_stage_hs
